// File: rtl/irq_dispatch.sv
// -----------------------------------------------------------------------------
// irq_dispatch
//   CPU-side consumer of the interrupt controller's 3-bit code. Incoming codes
//   are collected into a 7-bit pending set. At an instruction boundary, and
//   only while the global enable is set, the highest-numbered unmasked pending
//   code is dispatched. The block then issues a vector jump to the core, saves
//   the return PC and blocks further dispatch until reti. On return it restores
//   the saved PC and reopens eirq.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst         asynchronous, active-low reset
//   irq1..irq3  interrupt code bits 0..2 (code 0 = no event)
//   eirq        core can accept interrupts (gie set and idle)
//   gie_set     pulse: set global interrupt enable (IDLE only)
//   gie_clr     pulse: clear global interrupt enable (IDLE only, wins over set)
//   mask_we     mask write strobe
//   mask_wdata  new mask, bit k-1 enables code k
//   boundary    core is at an instruction boundary this cycle
//   pc          PC to resume at, sampled in the dispatch cycle
//   take        one-cycle pulse: core loads vec into PC
//   vec         vector address, held until the next dispatch
//   reti        pulse: handler return (honoured in SERVICE only)
//   ret_valid   one-cycle pulse: core loads ret_pc into PC
//   ret_pc      saved return PC
//   in_service  high in TAKE and SERVICE
//   cause       code being serviced
//   pending     pending set, bit k-1 = code k
// -----------------------------------------------------------------------------
module irq_dispatch #(
    parameter int unsigned        ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  VEC_BASE  = 16'h0004,
    parameter int unsigned        VEC_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq1,
    input  logic              irq2,
    input  logic              irq3,
    output logic              eirq,
    input  logic              gie_set,
    input  logic              gie_clr,
    input  logic              mask_we,
    input  logic [6:0]        mask_wdata,
    input  logic              boundary,
    input  logic [ADDR_W-1:0] pc,
    output logic              take,
    output logic [ADDR_W-1:0] vec,
    input  logic              reti,
    output logic              ret_valid,
    output logic [ADDR_W-1:0] ret_pc,
    output logic              in_service,
    output logic [2:0]        cause,
    output logic [6:0]        pending
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TAKE    = 2'd1,
        S_SERVICE = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        gie;
    logic [6:0]  mask;

    logic [2:0]  code;
    logic [6:0]  set_vec;
    logic [6:0]  clr_vec;
    logic [6:0]  eligible;
    logic [2:0]  sel;
    logic        dispatch;

    assign code     = {irq3, irq2, irq1};
    assign eligible = pending & mask;
    assign dispatch = (state == S_IDLE) && gie && boundary && (|eligible);

    // Decode of the incoming code and priority pick of the dispatch candidate.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves one unassigned would infer a latch.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        sel     = 3'd0;
        for (int k = 0; k < 7; k++) begin
            set_vec[k] = (code == 3'(k + 1));
            // Later iterations overwrite earlier ones, so the highest
            // eligible code wins.
            if (eligible[k]) sel = 3'(k + 1);
        end
        for (int k = 0; k < 7; k++) begin
            clr_vec[k] = dispatch && (sel == 3'(k + 1));
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (dispatch) state_nxt = S_TAKE;
            S_TAKE:    state_nxt = S_SERVICE;
            S_SERVICE: if (reti) state_nxt = S_RETURN;
            S_RETURN:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that held before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gie     <= 1'b0;
            mask    <= 7'h7F;
            pending <= '0;
            cause   <= '0;
            vec     <= '0;
            ret_pc  <= '0;
        end else begin
            // A code arriving for the bit being dispatched keeps it pending.
            pending <= (pending & ~clr_vec) | set_vec;

            if (mask_we) mask <= mask_wdata;

            if (dispatch) begin
                gie    <= 1'b0;
                cause  <= sel;
                ret_pc <= pc;
                vec    <= VEC_BASE + (ADDR_W'(sel) << VEC_SHIFT);
            end else if (state == S_IDLE) begin
                if (gie_clr)      gie <= 1'b0;
                else if (gie_set) gie <= 1'b1;
            end else if (state == S_RETURN) begin
                gie <= 1'b1;
            end
        end
    end

    assign eirq       = gie && (state == S_IDLE);
    assign take       = (state == S_TAKE);
    assign ret_valid  = (state == S_RETURN);
    assign in_service = (state == S_TAKE) || (state == S_SERVICE);

endmodule
